// File: rtl/case_conv_pkg.sv
//------------------------------------------------------------------------------
// Module      : case_conv_pkg
// Description : Shared mode encoding, FSM states, ASCII letter bounds and the
//               case bit index used by the case-conversion stream.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package case_conv_pkg;

    // Conversion modes as driven on the mode input
    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_UPPER  = 2'd1,
        MODE_LOWER  = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_e;

    // Packet-tracking states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_e;

    localparam logic [7:0] c_upper_min = 8'h41;
    localparam logic [7:0] c_upper_max = 8'h5A;
    localparam logic [7:0] c_lower_min = 8'h61;
    localparam logic [7:0] c_lower_max = 8'h7A;

    // ASCII upper and lower case differ only in this bit
    localparam int c_case_bit = 5;

    function automatic logic in_range(input logic [7:0] b,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/case_conv_byte.sv
//------------------------------------------------------------------------------
// Module      : case_conv_byte
// Description : Combinational single-byte ASCII case converter. Flips the case
//               bit of letters according to the mode and flags the change.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module case_conv_byte
    import case_conv_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic [1:0] i_mode,
    output logic [7:0] o_byte,
    output logic       o_changed
);

    logic w_is_upper;
    logic w_is_lower;
    logic w_flip;

    assign w_is_upper = in_range(i_byte, c_upper_min, c_upper_max);
    assign w_is_lower = in_range(i_byte, c_lower_min, c_lower_max);

    // Decide whether this byte's case bit must be inverted
    always_comb begin
        w_flip = 1'b0;
        case (mode_e'(i_mode))
            MODE_UPPER:  w_flip = w_is_lower;
            MODE_LOWER:  w_flip = w_is_upper;
            MODE_TOGGLE: w_flip = w_is_upper | w_is_lower;
            default:     w_flip = 1'b0;
        endcase
    end

    // Apply the flip to the case bit only; every other bit passes through
    always_comb begin
        o_byte             = i_byte;
        o_byte[c_case_bit] = i_byte[c_case_bit] ^ w_flip;
    end

    assign o_changed = w_flip;

endmodule

`default_nettype wire

// File: rtl/case_conv_stream.sv
//------------------------------------------------------------------------------
// Module      : case_conv_stream
// Description : Valid/ready byte-stream ASCII case converter with per-packet
//               mode latching, a 2-entry skid buffer and a saturating count
//               of changed bytes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module case_conv_stream
    import case_conv_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*LANES-1:0]   m_data,
    output logic                 m_last,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     conv_cnt
);

    localparam int c_data_w = 8 * LANES;
    // 5 bits hold the per-beat change count for up to 16 lanes
    localparam int c_inc_w  = 5;
    localparam int c_sum_w  = CNT_W + c_inc_w;
    localparam logic [c_sum_w-1:0] c_cnt_max = {{c_inc_w{1'b0}}, {CNT_W{1'b1}}};

    state_e                r_state;
    mode_e                 r_mode;
    logic                  r_s_ready;
    logic                  r_m_valid;
    logic [c_data_w-1:0]   r_m_data;
    logic                  r_m_last;
    logic                  r_skid_valid;
    logic [c_data_w-1:0]   r_skid_data;
    logic                  r_skid_last;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_load_out;
    logic                  w_skid_next;
    logic [1:0]            w_eff_mode;
    logic [c_data_w-1:0]   w_conv_data;
    logic [LANES-1:0]      w_changed;
    logic [c_inc_w-1:0]    w_inc;
    logic [c_sum_w-1:0]    w_sum;

    assign s_ready  = r_s_ready;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;
    assign conv_cnt = r_cnt;

    assign w_in_fire  = s_valid & r_s_ready;
    assign w_out_fire = r_m_valid & m_ready;
    // Output register can take a new beat when empty or draining this cycle
    assign w_load_out = w_out_fire | ~r_m_valid;
    // Skid holds a beat only when the output register is stuck
    assign w_skid_next = ~w_load_out & (r_skid_valid | w_in_fire);

    // Mid-packet beats use the mode captured at the first beat
    assign w_eff_mode = (r_state == ST_PKT) ? 2'(r_mode) : mode;

    for (genvar g = 0; g < LANES; g++) begin : g_lanes
        case_conv_byte u_byte (
            .i_byte    (s_data[8*g +: 8]),
            .i_mode    (w_eff_mode),
            .o_byte    (w_conv_data[8*g +: 8]),
            .o_changed (w_changed[g])
        );
    end

    // Count bytes changed in the current input beat
    always_comb begin
        w_inc = '0;
        for (int k = 0; k < LANES; k++) begin
            w_inc = w_inc + {{(c_inc_w-1){1'b0}}, w_changed[k]};
        end
    end

    assign w_sum = {{c_inc_w{1'b0}}, r_cnt} + {{CNT_W{1'b0}}, w_inc};

    // Packet tracking FSM: latch mode on the first beat of a multi-beat packet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_PASS;
        end else if (w_in_fire) begin
            case (r_state)
                ST_IDLE: begin
                    if (!s_last) begin
                        r_state <= ST_PKT;
                        r_mode  <= mode_e'(mode);
                    end
                end
                ST_PKT: begin
                    if (s_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer: output register first, skid register behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            if (w_load_out) begin
                if (r_skid_valid) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_skid_data;
                    r_m_last  <= r_skid_last;
                end else if (w_in_fire) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= w_conv_data;
                    r_m_last  <= s_last;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_data <= w_conv_data;
                r_skid_last <= s_last;
            end
            r_skid_valid <= w_skid_next;
            r_s_ready    <= ~w_skid_next;
        end
    end

    // Saturating changed-byte counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_in_fire) begin
            if (w_sum > c_cnt_max) begin
                r_cnt <= {CNT_W{1'b1}};
            end else begin
                r_cnt <= w_sum[CNT_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/case_conv_stream.md
CASE_CONV_STREAM -- requirements
Module: case_conv_stream

Interface
REQ-001 SHALL have parameter LANES, default 4, giving bytes per beat (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the converted-byte counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port mode, input, 2, the conversion mode: 0 pass, 1 upper, 2 lower, 3 toggle.
REQ-006 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, 8*LANES) and s_last (input, 1) as the input stream.
REQ-007 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, 8*LANES) and m_last (output, 1) as the output stream.
REQ-008 SHALL have port cnt_clr, input, 1, a synchronous clear of conv_cnt.
REQ-009 SHALL have port conv_cnt, output, CNT_W, the count of bytes whose value was changed.

Function
REQ-010 SHALL transfer a beat on either port only when valid and ready are both high in the same cycle.
REQ-011 SHALL place byte k of a beat in data bits [8k+7:8k], with byte 0 the first character.
REQ-012 SHALL convert only ASCII letters: 0x41-0x5A (A-Z) and 0x61-0x7A (a-z).
REQ-013 SHALL pass every other byte unchanged, including 0x40, 0x5B, 0x60, 0x7B and 0x80-0xFF.
REQ-014 SHALL apply the modes as follows:
- upper: clears bit 5 of a-z.
- lower: sets bit 5 of A-Z.
- toggle: inverts bit 5 of any letter.
- pass: changes nothing.
REQ-015 SHALL run a state machine with states IDLE and PKT:
- IDLE to PKT on an accepted beat with s_last=0; the mode is latched at that transfer.
- PKT to IDLE on an accepted beat with s_last=1.
- An accepted beat in IDLE with s_last=1 is a one-beat packet and uses the live mode.
REQ-016 SHALL convert beats in PKT with the latched mode, so mode changes mid-packet have no effect until the next packet.
REQ-017 SHALL present a beat on m_* exactly 1 cycle after its input transfer when the output is not stalled.
REQ-018 SHALL buffer with a 2-entry skid buffer so that s_ready is a registered signal and never combinationally depends on m_ready.
REQ-019 SHALL sustain 1 beat/cycle throughput while m_ready stays high.
REQ-020 SHALL drop s_ready in the cycle after the skid buffer fills.
REQ-021 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-022 SHALL keep beat order and m_last alignment identical to the input.
REQ-023 SHALL increase conv_cnt, when a beat is accepted on the input, by the number of bytes in that beat whose output differs from the input.
REQ-024 SHALL saturate conv_cnt at 2^CNT_W-1 and never wrap.
REQ-025 SHALL give cnt_clr priority over a same-cycle increment: the counter becomes 0 and that beat's contribution is discarded.
REQ-026 SHALL accept an input beat and emit an output beat in the same cycle when the buffer holds 1 entry, leaving the occupancy unchanged.

Reset
REQ-027 SHALL, while rst=1 on a clock edge, set:
- state IDLE, latched mode 0, buffer empty;
- m_valid=0, m_data=0, m_last=0;
- conv_cnt=0, s_ready=0.
REQ-028 SHALL raise s_ready on the first clock edge at which rst=0.
REQ-029 SHALL discard any partial packet on reset mid-packet; no beat of it appears on m_* after reset.

Structure
REQ-030 SHALL put the mode encoding enum, the letter bounds (0x41, 0x5A, 0x61, 0x7A) and the case bit index 5 in a shared package case_conv_pkg.
REQ-031 SHALL implement conversion in a combinational sub-module case_conv_byte, instantiated LANES times.
REQ-032 SHALL have case_conv_byte take one byte plus a mode and produce the converted byte plus a changed flag.
REQ-033 SHALL keep the FSM, skid buffer and counter in case_conv_stream.

Verification
REQ-034 SHALL cover: LANES=4, mode=1, m_ready=1, one beat "aZ{b" (0x61,0x5A,0x7B,0x62) with last -> next cycle m_data "AZ{B", m_last=1, conv_cnt=2.
REQ-035 SHALL cover: mode=3 set on beat 1 of a 3-beat packet, mode=2 applied on beats 2-3 -> all 3 beats toggled; the next packet uses mode=2.
REQ-036 SHALL cover: m_ready=0 for 5 cycles during a 6-beat stream -> s_ready low from the cycle after 2 beats are buffered, no loss or duplication, order preserved after release.
REQ-037 SHALL cover: CNT_W=4 with 20 letters converted -> conv_cnt sticks at 15; cnt_clr together with a convertible beat -> conv_cnt=0.
REQ-038 SHALL cover: boundary bytes 0x40, 0x5B, 0x60, 0x7B, 0xE1 in every mode -> output equals input and conv_cnt is unchanged.
REQ-039 SHALL cover: rst asserted one cycle after beat 2 of a 4-beat packet -> m_valid=0, conv_cnt=0, state IDLE; a following packet is converted with its own mode.
